// File: rtl/io_port_bank_if.sv
// IO port bank bus interface.
// Carries the Z80 IO cycle qualifiers, address/data, per-port decode
// configuration and read-mux sources toward the bank, and the register
// contents, access strobes, read data and lock state back out.
//   master : drives cycle, address, data and configuration; observes results
//   slave  : the port bank itself
interface io_port_bank_if #(
  parameter int NPORTS = 4,
  parameter int DW     = 8,
  parameter int AW     = 16
);
  logic [NPORTS-1:0]    en;
  logic                 ioreq;
  logic                 rd;
  logic                 wr;
  logic [AW-1:0]        a;
  logic [DW-1:0]        d;
  logic [NPORTS*AW-1:0] match;
  logic [NPORTS*AW-1:0] mask;
  logic [NPORTS-1:0]    readable;
  logic [NPORTS-1:0]    ext_sel;
  logic [NPORTS*DW-1:0] ext_data;
  logic                 unlock;
  logic [NPORTS*DW-1:0] regs;
  logic [NPORTS-1:0]    wr_stb;
  logic [NPORTS-1:0]    rd_stb;
  logic [DW-1:0]        d_out;
  logic                 d_out_active;
  logic                 locked;

  modport master (
    output en, ioreq, rd, wr, a, d, match, mask, readable, ext_sel, ext_data, unlock,
    input  regs, wr_stb, rd_stb, d_out, d_out_active, locked
  );

  modport slave (
    input  en, ioreq, rd, wr, a, d, match, mask, readable, ext_sel, ext_data, unlock,
    output regs, wr_stb, rd_stb, d_out, d_out_active, locked
  );
endinterface

// File: rtl/io_port_bank.sv
// IO port bank: NPORTS address-decoded registers on a Z80 IO bus.
// Ports:
//   clk28 - sole clock, all state on its rising edge
//   rst   - asynchronous active-high reset
//   bus   - io_port_bank_if slave: cycle qualifiers, address/data, per-port
//           match/mask/enable/readable/ext-read config, unlock override;
//           outputs regs, wr_stb/rd_stb, d_out/d_out_active, locked
// One access is taken per IO cycle (on the IDLE->ACTIVE transition); a write
// lands in every hit port that the lock does not freeze.
module io_port_bank #(
  parameter int                   NPORTS    = 4,
  parameter int                   DW        = 8,
  parameter int                   AW        = 16,
  parameter logic [NPORTS*DW-1:0] RESET_VAL = '0,
  parameter int                   LOCK_PORT = 0,
  parameter int                   LOCK_BIT  = 5,
  parameter logic [NPORTS-1:0]    LOCKABLE  = '1
) (
  input  logic           clk28,
  input  logic           rst,
  io_port_bank_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_BLOCK,
    ST_IDLE,
    ST_ACTIVE
  } state_t;

  state_t state_q, state_d;

  logic [NPORTS*DW-1:0] regs_q, regs_d;
  logic [NPORTS-1:0]    wr_stb_q, wr_stb_d;
  logic [NPORTS-1:0]    rd_stb_q, rd_stb_d;
  logic [DW-1:0]        d_out_q, d_out_d;
  logic                 d_out_active_q, d_out_active_d;
  logic                 locked_q, locked_d;

  logic [NPORTS-1:0]    hit;
  logic [NPORTS-1:0]    rd_hit;
  logic                 start;
  logic                 do_write;
  logic                 do_read;
  logic                 found;

  // Address decode
  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < NPORTS; i++) begin
      hit[i] = bus.en[i] & bus.ioreq &
               (((bus.a ^ bus.match[i*AW +: AW]) & bus.mask[i*AW +: AW]) == '0);
    end
  end

  // FSM state register; BLOCK after reset swallows a cycle already in flight
  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) state_q <= ST_BLOCK;
    else     state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BLOCK:  if (!bus.ioreq) state_d = ST_IDLE;
      ST_IDLE:   if (bus.ioreq && (bus.rd || bus.wr)) state_d = ST_ACTIVE;
      ST_ACTIVE: if (!bus.ioreq) state_d = ST_IDLE;
      default:   state_d = ST_BLOCK;
    endcase
  end

  // FSM outputs: access qualifiers for the single edge that starts a cycle
  always_comb begin
    start    = (state_q == ST_IDLE) & bus.ioreq & (bus.rd | bus.wr);
    do_write = start & bus.wr & ~bus.rd;
    do_read  = start & bus.rd;
  end

  // Register file, strobes, lock and read mux
  always_comb begin
    regs_d   = regs_q;
    wr_stb_d = '0;
    locked_d = locked_q;
    for (int unsigned i = 0; i < NPORTS; i++) begin
      if (do_write && hit[i] && (!(locked_q && LOCKABLE[i]) || bus.unlock)) begin
        regs_d[i*DW +: DW] = bus.d;
        wr_stb_d[i]        = 1'b1;
      end
    end
    // The lock only changes on a write that was itself permitted
    if (wr_stb_d[LOCK_PORT]) locked_d = bus.d[LOCK_BIT];

    rd_stb_d       = do_read ? hit : '0;
    rd_hit         = hit & bus.readable;
    d_out_active_d = bus.rd & (|rd_hit);

    // Lowest-index readable hit wins; otherwise hold the last value
    d_out_d = d_out_q;
    found   = 1'b0;
    for (int unsigned i = 0; i < NPORTS; i++) begin
      if (rd_hit[i] && !found) begin
        found   = 1'b1;
        d_out_d = bus.ext_sel[i] ? bus.ext_data[i*DW +: DW] : regs_q[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      regs_q         <= RESET_VAL;
      wr_stb_q       <= '0;
      rd_stb_q       <= '0;
      d_out_q        <= '0;
      d_out_active_q <= 1'b0;
      locked_q       <= 1'b0;
    end else begin
      regs_q         <= regs_d;
      wr_stb_q       <= wr_stb_d;
      rd_stb_q       <= rd_stb_d;
      d_out_q        <= d_out_d;
      d_out_active_q <= d_out_active_d;
      locked_q       <= locked_d;
    end
  end

  assign bus.regs         = regs_q;
  assign bus.wr_stb       = wr_stb_q;
  assign bus.rd_stb       = rd_stb_q;
  assign bus.d_out        = d_out_q;
  assign bus.d_out_active = d_out_active_q;
  assign bus.locked       = locked_q;

endmodule

// File: tb/tb_io_port_bank.sv
// Testbench for io_port_bank: directed scenarios followed by randomized IO
// cycles, all checked every clock against a behavioural model of the bank.
module tb_io_port_bank;
  localparam int NP = 4;
  localparam int DW = 8;
  localparam int AW = 16;
  localparam logic [NP*DW-1:0] RV   = 32'h8844_2211;
  localparam logic [NP-1:0]    LOCKM = 4'b1111;

  logic clk28 = 1'b0;
  logic rst;
  always #5 clk28 = ~clk28;

  io_port_bank_if #(.NPORTS(NP), .DW(DW), .AW(AW)) bus ();

  io_port_bank #(
    .NPORTS(NP), .DW(DW), .AW(AW), .RESET_VAL(RV),
    .LOCK_PORT(0), .LOCK_BIT(5), .LOCKABLE(LOCKM)
  ) dut (
    .clk28(clk28),
    .rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model state: register values, lock, last strobes and read outputs, plus
  // "armed" (ioreq seen low since reset) and "taken" (this cycle consumed).
  logic [DW-1:0] m_regs [NP];
  logic          m_locked;
  logic [NP-1:0] m_wr, m_rd;
  logic [DW-1:0] m_dout;
  logic          m_dact;
  logic          m_armed, m_taken;
  int            wr_pulses, rd_pulses;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    logic [NP*DW-1:0] rv;
    rv = RV;
    for (int i = 0; i < NP; i++) m_regs[i] = rv[i*DW +: DW];
    m_locked = 1'b0; m_wr = '0; m_rd = '0; m_dout = '0; m_dact = 1'b0;
    m_armed = 1'b0; m_taken = 1'b0;
  endtask

  function automatic bit port_hit(int i);
    logic [AW-1:0] mt, mk;
    mt = bus.match[i*AW +: AW];
    mk = bus.mask[i*AW +: AW];
    return bus.en[i] && bus.ioreq && (((bus.a ^ mt) & mk) == 0);
  endfunction

  // Advance the model by one clock using the inputs currently applied
  task automatic model_edge();
    logic [DW-1:0] nregs [NP];
    logic          nlocked;
    logic [NP-1:0] lockable;
    bit            accept, any_rd, first;
    if (rst) begin
      model_reset();
      return;
    end
    lockable = LOCKM;
    accept = m_armed && !m_taken && bus.ioreq && (bus.rd || bus.wr);
    nlocked = m_locked;
    m_wr = '0; m_rd = '0;
    any_rd = 0; first = 1;
    for (int i = 0; i < NP; i++) begin
      nregs[i] = m_regs[i];
      if (port_hit(i)) begin
        if (accept && bus.wr && !bus.rd &&
            (!m_locked || !lockable[i] || bus.unlock)) begin
          nregs[i] = bus.d;
          m_wr[i] = 1'b1;
          if (i == 0) nlocked = bus.d[5];
        end
        if (accept && bus.rd) m_rd[i] = 1'b1;
        if (bus.readable[i]) begin
          any_rd = 1;
          if (first) begin
            m_dout = bus.ext_sel[i] ? bus.ext_data[i*DW +: DW] : m_regs[i];
            first = 0;
          end
        end
      end
    end
    m_dact = bus.rd && any_rd;
    for (int i = 0; i < NP; i++) m_regs[i] = nregs[i];
    m_locked = nlocked;
    if (!bus.ioreq) begin
      m_armed = 1'b1;
      m_taken = 1'b0;
    end else if (accept) begin
      m_taken = 1'b1;
    end
  endtask

  task automatic check_all(input string ctx);
    logic [NP*DW-1:0] er;
    for (int i = 0; i < NP; i++) er[i*DW +: DW] = m_regs[i];
    check({ctx, ":regs"},   64'(bus.regs), 64'(er));
    check({ctx, ":wr_stb"}, 64'(bus.wr_stb), 64'(m_wr));
    check({ctx, ":rd_stb"}, 64'(bus.rd_stb), 64'(m_rd));
    check({ctx, ":d_out"},  64'(bus.d_out), 64'(m_dout));
    check({ctx, ":d_act"},  64'(bus.d_out_active), 64'(m_dact));
    check({ctx, ":locked"}, 64'(bus.locked), 64'(m_locked));
  endtask

  task automatic cyc(input string ctx);
    model_edge();
    @(posedge clk28);
    #1;
    check_all(ctx);
    wr_pulses += int'(bus.wr_stb[0]);
    rd_pulses += int'(bus.rd_stb[2]);
  endtask

  task automatic io_cycle(input string ctx, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data, input logic rdv,
                          input logic wrv, input int hold);
    wr_pulses = 0; rd_pulses = 0;
    bus.a = addr; bus.d = data; bus.rd = rdv; bus.wr = wrv; bus.ioreq = 1'b1;
    repeat (hold) cyc(ctx);
    bus.ioreq = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0;
    repeat (2) cyc(ctx);
  endtask

  initial begin
    rst = 1'b1;
    bus.en = '1; bus.ioreq = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0;
    bus.a = '0; bus.d = '0; bus.unlock = 1'b0;
    bus.match = {16'h1234, 16'h00FE, 16'h00FE, 16'h7FFD};
    bus.mask  = {16'hFFFF, 16'h00FF, 16'h00FF, 16'h8002};
    bus.readable = 4'b0110; bus.ext_sel = 4'b0100;
    bus.ext_data = {8'h33, 8'h5A, 8'h77, 8'h99};
    model_reset();
    #3;
    check("rst_async:regs", 64'(bus.regs), 64'(RV));
    repeat (2) cyc("reset");
    rst = 1'b0;
    repeat (2) cyc("idle");

    // Basic write, wr held 10 clocks: one strobe
    io_cycle("basic_wr", 16'h7FFD, 8'h17, 1'b0, 1'b1, 10);
    check("basic_wr:regs0", 64'(bus.regs[7:0]), 64'h17);
    check("basic_wr:pulses", 64'(wr_pulses), 64'd1);

    // Write ports 1 and 2 (both decode 00FE)
    io_cycle("wr12", 16'h00FE, 8'h11, 1'b0, 1'b1, 3);

    // Priority read: port 1 beats ext-selected port 2
    io_cycle("prio_rd", 16'h00FE, 8'h00, 1'b1, 1'b0, 4);
    check("prio_rd:d_out", 64'(bus.d_out), 64'h11);

    // Ext read: port 1 disabled, port 2 supplies ext_data
    bus.en = 4'b1101;
    bus.ext_data = {8'h33, 8'hA5, 8'h77, 8'h99};
    io_cycle("ext_rd", 16'h00FE, 8'h00, 1'b1, 1'b0, 4);
    check("ext_rd:d_out", 64'(bus.d_out), 64'hA5);
    check("ext_rd:pulses", 64'(rd_pulses), 64'd1);
    bus.en = '1;

    // Lock, ignored write, unlocked write clears lock
    io_cycle("lock_set", 16'h7FFD, 8'h20, 1'b0, 1'b1, 3);
    check("lock_set:locked", 64'(bus.locked), 64'd1);
    io_cycle("lock_blk", 16'h7FFD, 8'h05, 1'b0, 1'b1, 3);
    check("lock_blk:regs0", 64'(bus.regs[7:0]), 64'h20);
    check("lock_blk:pulses", 64'(wr_pulses), 64'd0);
    bus.unlock = 1'b1;
    io_cycle("unlock", 16'h7FFD, 8'h05, 1'b0, 1'b1, 3);
    bus.unlock = 1'b0;
    check("unlock:regs0", 64'(bus.regs[7:0]), 64'h05);
    check("unlock:locked", 64'(bus.locked), 64'd0);

    // rd=wr=1 is a read
    io_cycle("rdwr", 16'h7FFD, 8'hFF, 1'b1, 1'b1, 3);
    check("rdwr:regs0", 64'(bus.regs[7:0]), 64'h05);

    // Reset in the middle of a write cycle with ioreq held through release
    bus.a = 16'h7FFD; bus.d = 8'h3C; bus.wr = 1'b1; bus.ioreq = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid:regs", 64'(bus.regs), 64'(RV));
    model_reset();
    repeat (2) cyc("rst_mid_hold");
    rst = 1'b0;
    repeat (4) cyc("rst_mid_rel");
    check("rst_mid:nowrite", 64'(bus.regs), 64'(RV));
    bus.ioreq = 1'b0; bus.wr = 1'b0;
    repeat (2) cyc("rst_mid_idle");
    io_cycle("post_rst_wr", 16'h7FFD, 8'h3C, 1'b0, 1'b1, 3);
    check("post_rst_wr:regs0", 64'(bus.regs[7:0]), 64'h3C);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      int sel;
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 149) == 0) rst = 1'b1;
      if ($urandom_range(0, 3) == 0) begin
        bus.ioreq = ~bus.ioreq;
        if (bus.ioreq) begin
          sel = $urandom_range(0, 4);
          case (sel)
            0: bus.a = 16'h7FFD;
            1: bus.a = 16'h00FE;
            2: bus.a = 16'h1234;
            3: bus.a = 16'h3FFD;
            default: bus.a = 16'($urandom);
          endcase
          bus.d  = 8'($urandom);
          bus.rd = 1'($urandom);
          bus.wr = 1'($urandom);
        end else begin
          bus.rd = 1'b0; bus.wr = 1'b0;
        end
      end
      if ($urandom_range(0, 9) == 0) bus.rd = 1'($urandom);
      if ($urandom_range(0, 7) == 0) bus.en = 4'($urandom) | 4'b1010;
      else if ($urandom_range(0, 7) == 0) bus.en = '1;
      bus.unlock = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 5) == 0) begin
        bus.readable = 4'($urandom);
        bus.ext_sel  = 4'($urandom);
        bus.ext_data = $urandom;
      end
      cyc("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/io_port_bank.md
IO_PORT_BANK -- requirements
Module: io_port_bank

Interface
REQ-001 SHALL have parameter NPORTS, default 4, number of port channels (1..16).
REQ-002 SHALL have parameter DW, default 8, data width.
REQ-003 SHALL have parameter AW, default 16, address width.
REQ-004 SHALL have parameter RESET_VAL, default all-zero, packed NPORTS*DW per-port reset values.
REQ-005 SHALL have parameter LOCK_PORT, default 0, index of the port whose write controls the lock.
REQ-006 SHALL have parameter LOCK_BIT, default 5, bit of LOCK_PORT data that sets the lock.
REQ-007 SHALL have parameter LOCKABLE, default all-ones, NPORTS mask of ports frozen while locked.
REQ-008 SHALL have clk28 input 1, sole clock, all state on its rising edge.
REQ-009 SHALL have rst input 1, asynchronous active-high reset.
REQ-010 SHALL have en, ioreq, rd and wr inputs: en is NPORTS per-port enable; ioreq, rd and wr are 1-bit Z80 IO cycle qualifiers.
REQ-011 SHALL have a input AW and d input DW: IO address and write data.
REQ-012 SHALL have match and mask inputs, NPORTS*AW each: per-port address value and significant-bit mask.
REQ-013 SHALL have readable input NPORTS: port may drive read data.
REQ-014 SHALL have ext_sel input NPORTS and ext_data input NPORTS*DW: read from ext_data instead of the register.
REQ-015 SHALL have unlock input 1: overrides the lock for writes.
REQ-016 SHALL have regs output NPORTS*DW: port register contents.
REQ-017 SHALL have wr_stb and rd_stb outputs NPORTS: one-cycle per-port access strobes.
REQ-018 SHALL have d_out output DW and d_out_active output 1: read data and bus-drive enable.
REQ-019 SHALL have locked output 1: lock state.

Function
REQ-020 SHALL compute hit[i] = en[i] & ioreq & (((a ^ match_i) & mask_i) == 0), combinationally.
REQ-021 SHALL run cycle FSM BLOCK/IDLE/ACTIVE:
- BLOCK->IDLE when ioreq=0.
- IDLE->ACTIVE when ioreq & (rd|wr).
- ACTIVE->IDLE when ioreq=0.
REQ-022 SHALL, on the IDLE->ACTIVE edge with wr=1 and rd=0, write d into every hit port not blocked by lock, exactly once per cycle.
REQ-023 SHALL assert wr_stb[i] for exactly the one clock following that edge, for each port written.
REQ-024 SHALL make register updates visible on regs in that same clock (latency 1).
REQ-025 SHALL treat rd=wr=1 as a read: no register write and no wr_stb.
REQ-026 SHALL block writes to port i when locked=1 and LOCKABLE[i]=1, unless unlock=1; blocked writes give no wr_stb.
REQ-027 SHALL, on a permitted LOCK_PORT write, set locked to d[LOCK_BIT] in the same clock as the register update.
REQ-028 SHALL allow LOCK_PORT to clear the lock only if that write is permitted (not LOCKABLE, or unlock=1).
REQ-029 SHALL, on the IDLE->ACTIVE edge with rd=1, pulse rd_stb[i] for one clock on each hit port.
REQ-030 SHALL register d_out_active = rd & OR(hit & readable) every clock, so it deasserts one clock after rd or ioreq falls.
REQ-031 SHALL register d_out every clock from the lowest-index readable hit port: ext_data_i if ext_sel[i], else regs_i.
REQ-032 SHALL hold d_out at its last value when no readable port hits.
REQ-033 SHALL keep all other strobes at 0 when no port hits; the FSM still tracks the cycle.

Reset
REQ-034 SHALL, while rst=1 (asynchronous), drive regs=RESET_VAL, locked=0, wr_stb=0, rd_stb=0, d_out=0, d_out_active=0, FSM=BLOCK.
REQ-035 SHALL ignore an IO cycle already in progress at rst release, accepting access only after ioreq=0 is seen.

Verification
REQ-036 SHALL cover basic write: match0=7FFD, mask0=8002, write a=7FFD, d=0x17 -> regs0=0x17 one clock after edge; wr_stb0 single pulse although wr held 10 clocks.
REQ-037 SHALL cover lock: write port0 d=0x20 -> locked=1; next write d=0x05 ignored, regs0=0x20; same with unlock=1 -> regs0=0x05, locked=0.
REQ-038 SHALL cover priority read: ports 1 and 2 both hit a=00FE, readable=0110, regs1=0x11, ext_sel2=1 -> d_out=0x11, d_out_active=1; drops 1 clock after rd low.
REQ-039 SHALL cover ext read: only port 2 hits with ext_data2=0xA5 -> d_out=0xA5, rd_stb2 one pulse, regs unchanged.
REQ-040 SHALL cover reset mid-cycle: rst pulse during wr cycle, d=0x3C, ioreq held -> regs=RESET_VAL, no write after release; next full cycle writes normally.
REQ-041 SHALL cover rd=wr=1: a=7FFD, d=0xFF -> no regs change, no wr_stb, rd_stb0 pulses.
